// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default frame constants and FSM state type.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DEF_DBIT    = 8;
  localparam int unsigned DEF_OS      = 16;
  localparam int unsigned DEF_SB_TICK = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: pops words from a fall-through FIFO and serialises start/data/stop.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DEF_DBIT,
  parameter int unsigned SB_TICK = DEF_SB_TICK,
  parameter int unsigned OS      = DEF_OS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int unsigned TMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] OS_LAST = TW'(OS - 1);
  localparam logic [TW-1:0] SB_LAST = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] NB_LAST = NW'(DBIT - 1);

  tx_state_e       state_q, state_d;
  logic [TW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          b_d     = fifo_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_data;
`endif
          s_d     = '0;
          n_d     = '0;
          state_d = START;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == OS_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NB_LAST) begin
              n_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (s_q == SB_LAST) begin
            s_d          = '0;
            tx_done_tick = 1'b1;
            state_d      = IDLE;
          end else begin
            s_d = s_q + TW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset dominates the combinational strobes so a held reset never pops or signals done.
    if (rst) begin
      fifo_rd      = 1'b0;
      tx_done_tick = 1'b0;
    end
  end

  // Line level is derived from the upcoming state so tx can be a plain register.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      b_q      <= b_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule
